sel_reg_mux: RTL and testbench
==============================

# sel_reg_mux

Parametrised N:1 datapath selector with a registered output, successor to the fixed-width 2/3/4-input selectors in the multi-cycle MIPS datapath. Selects one of NUM_IN inputs under a binary select and latches it on a load strobe. It also keeps the previous latched value, a valid flag, a sticky illegal-select error and a saturating load counter. It sits between datapath sources (PC, A/B, ALUOut, MDR, immediates) and their consumers, so the selector and the holding register are one unit.

## Interface
- WIDTH, 32, data width of each input and of the output
- NUM_IN, 4, number of data inputs, 2..16; need not be a power of two
- SEL_W, $clog2(NUM_IN), select width, minimum 1
- CNT_W, 8, load-counter width
- CONST_VAL, 32'd4, constant for the optional injected input (see Configuration)
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- in_flat  in  NUM_IN*WIDTH  packed inputs; input k is in_flat[k*WIDTH +: WIDTH]
- sel  in  SEL_W  select code, sampled only when load=1
- load  in  1  capture strobe
- clr  in  1  clears valid, err and the counter; does not change data
- out_q  out  WIDTH  currently latched value
- prev_q  out  WIDTH  value of out_q before the last successful load
- mux_c  out  WIDTH  combinational selected value; illegal sel gives 0
- valid_q  out  1  out_q holds a captured value
- err_q  out  1  sticky: a load with an illegal sel occurred
- cnt_q  out  CNT_W  number of successful loads, saturating

## Operation
- Legal sel: sel < NUM_IN. Illegal sel: sel >= NUM_IN. Illegal codes exist only when NUM_IN is not a power of two.
- Successful load (load=1, legal sel):
  - prev_q <= out_q
  - out_q <= input[sel]
  - valid_q <= 1
  - cnt_q <= cnt_q+1, saturating at all-ones
- Illegal load (load=1, illegal sel):
  - out_q, prev_q and cnt_q hold
  - err_q <= 1
  - valid_q holds
- load=0: all data registers hold.
- clr=1 clears valid_q, err_q and cnt_q. It does not change out_q or prev_q.
- clr and load in the same cycle: load is evaluated after clr.
  - Legal load gives valid_q=1, err_q=0, cnt_q=1, and out_q updates.
  - Illegal load gives valid_q=0, err_q=1, cnt_q=0.
- Loading the same sel on consecutive cycles is allowed. Each load counts and shifts out_q into prev_q.

## Timing
- Reset (rst_n=0 at a rising edge) has priority over load and clr. After reset: out_q=0, prev_q=0, valid_q=0, err_q=0, cnt_q=0.
- Reset asserted mid-sequence discards all state on that edge. The first load after rst_n returns high behaves as the first load after power-up.
- Latency:
  - mux_c is combinational, zero cycles, valid while inputs are stable.
  - out_q, valid_q and cnt_q reflect a load one cycle after the load edge.
  - err_q rises one cycle after the illegal load edge.
- in_flat and sel have no setup requirement beyond the clk edge when load=1.

## Configuration
- Macro: SEL_REG_MUX_CONST_EN.
- Defined:
  - Select code 1 returns CONST_VAL instead of in_flat slot 1; slot 1 is ignored.
  - Applies to both mux_c and out_q.
  - Provides the PC+4 source without an external constant.
  - Requires NUM_IN >= 2.
- Undefined: all NUM_IN slots come from in_flat.

## Structure
- Package sel_pkg holds:
  - the default WIDTH and CNT_W localparams
  - a SEL_ILLEGAL helper function (sel >= NUM_IN)
  - the shared 4-input source-code constants SRC_REG=0, SRC_CONST4=1, SRC_IMM=2, SRC_IMM_SH=3
- One sub-module, sel_mux_comb: the purely combinational N:1 selector that produces mux_c plus an illegal flag. sel_reg_mux instantiates it and adds the registers, counter and flags.

## Test plan
- Reset: rst_n=0 for 2 cycles, then 1. All outputs read 0, and mux_c follows sel on idle inputs.
- Basic load (NUM_IN=4): inputs 0x10, 0x20, 0x30, 0x40; load with sel=2, then sel=0.
  - After the first load: out_q=0x30, prev_q=0, valid_q=1, cnt_q=1.
  - After the second load: out_q=0x10, prev_q=0x30, cnt_q=2.
- Illegal select (NUM_IN=3): load with sel=3. out_q holds, err_q=1, cnt_q unchanged, mux_c=0. Then clr: err_q=0, valid_q=0.
- Simultaneous clr+load: cnt_q=5, load sel=1 with clr=1 in the same cycle. Next cycle: cnt_q=1, valid_q=1, err_q=0.
- Counter saturation (CNT_W=4): 20 consecutive legal loads. cnt_q stops at 15, and prev_q/out_q keep shifting.
- SEL_REG_MUX_CONST_EN defined: slot 1 driven with 0xDEAD, load sel=1. out_q=0x00000004. Rerun without the macro: out_q=0xDEAD.

Source files
------------

// File: rtl/sel_pkg.sv
// rtl/sel_pkg.sv - shared defaults, select-code constants and illegal-select helper for sel_reg_mux
package sel_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 8;

    // Source codes shared by the 4-input datapath selectors.
    localparam logic [1:0] SRC_REG    = 2'd0;
    localparam logic [1:0] SRC_CONST4 = 2'd1;
    localparam logic [1:0] SRC_IMM    = 2'd2;
    localparam logic [1:0] SRC_IMM_SH = 2'd3;

    function automatic logic SEL_ILLEGAL(input int unsigned sel_v, input int unsigned num_in);
        return (sel_v >= num_in);
    endfunction

endpackage

// File: rtl/sel_mux_comb.sv
// rtl/sel_mux_comb.sv - combinational N:1 selector with illegal-select flag; optional SEL_REG_MUX_CONST_EN
module sel_mux_comb
    import sel_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
`ifdef SEL_REG_MUX_CONST_EN
    ,
    parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(32'd4)
`endif
) (
    input  logic [NUM_IN*WIDTH-1:0] in_flat,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        mux_c,
    output logic                    illegal_c
);

    always_comb begin
        mux_c     = '0;
        illegal_c = SEL_ILLEGAL(32'(sel), 32'(NUM_IN));
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                mux_c = in_flat[k*WIDTH +: WIDTH];
            end
        end
`ifdef SEL_REG_MUX_CONST_EN
        // Slot 1 is the built-in PC+4 style constant; the external slot is ignored.
        if (sel == SEL_W'(SRC_CONST4)) begin
            mux_c = CONST_VAL;
        end
`endif
    end

endmodule

// File: rtl/sel_reg_mux.sv
// rtl/sel_reg_mux.sv - N:1 selector with load register, history, valid/err flags and load counter; optional SEL_REG_MUX_CONST_EN
module sel_reg_mux
    import sel_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    parameter int CNT_W  = DEFAULT_CNT_W
`ifdef SEL_REG_MUX_CONST_EN
    ,
    parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(32'd4)
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_flat,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    load,
    input  logic                    clr,
    output logic [WIDTH-1:0]        out_q,
    output logic [WIDTH-1:0]        prev_q,
    output logic [WIDTH-1:0]        mux_c,
    output logic                    valid_q,
    output logic                    err_q,
    output logic [CNT_W-1:0]        cnt_q
);

    logic             illegal_c;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] prev_d;
    logic             valid_d;
    logic             err_d;
    logic [CNT_W-1:0] cnt_d;

    sel_mux_comb #(
        .WIDTH     (WIDTH),
        .NUM_IN    (NUM_IN),
        .SEL_W     (SEL_W)
`ifdef SEL_REG_MUX_CONST_EN
        ,
        .CONST_VAL (CONST_VAL)
`endif
    ) u_mux (
        .in_flat   (in_flat),
        .sel       (sel),
        .mux_c     (mux_c),
        .illegal_c (illegal_c)
    );

    // clr is applied first so a same-cycle load sees cleared flags and counter.
    always_comb begin
        out_d   = out_q;
        prev_d  = prev_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (clr) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
            cnt_d   = '0;
        end
        if (load) begin
            if (illegal_c) begin
                err_d = 1'b1;
            end else begin
                prev_d  = out_q;
                out_d   = mux_c;
                valid_d = 1'b1;
                if (cnt_d != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_d + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            prev_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            out_q   <= out_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sel_reg_mux.sv
// tb/tb_sel_reg_mux.sv - self-checking bench for sel_reg_mux (NUM_IN=3, CNT_W=4), with or without SEL_REG_MUX_CONST_EN
module tb_sel_reg_mux;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = 15;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_IN*WIDTH-1:0] in_flat;
    logic [SEL_W-1:0]        sel;
    logic                    load;
    logic                    clr;
    logic [WIDTH-1:0]        out_q;
    logic [WIDTH-1:0]        prev_q;
    logic [WIDTH-1:0]        mux_c;
    logic                    valid_q;
    logic                    err_q;
    logic [CNT_W-1:0]        cnt_q;

    sel_reg_mux #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_flat (in_flat),
        .sel     (sel),
        .load    (load),
        .clr     (clr),
        .out_q   (out_q),
        .prev_q  (prev_q),
        .mux_c   (mux_c),
        .valid_q (valid_q),
        .err_q   (err_q),
        .cnt_q   (cnt_q)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [31:0] m_in [NUM_IN];
    logic [31:0] m_out, m_prev;
    int          m_cnt;
    bit          m_valid, m_err;
    logic [31:0] last_mux;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] ref_mux(input int s);
        if (s >= NUM_IN) return 32'h0;
`ifdef SEL_REG_MUX_CONST_EN
        if (s == 1) return 32'd4;
`endif
        return m_in[s];
    endfunction

    task automatic model_reset();
        m_out = 0; m_prev = 0; m_cnt = 0; m_valid = 0; m_err = 0;
    endtask

    // One clock: drive inputs, check mux_c, clock, update model.
    task automatic cycle(input logic [31:0] a, b, c, input int s, input bit ld, cl, rn);
        logic [31:0] src;
        in_flat = {c, b, a};
        sel     = SEL_W'(s);
        load    = ld;
        clr     = cl;
        rst_n   = rn;
        m_in[0] = a; m_in[1] = b; m_in[2] = c;
        #1;
        last_mux = mux_c;
        chk("mux_c", mux_c, ref_mux(s));
        src = ref_mux(s);
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            if (cl) begin m_valid = 0; m_err = 0; m_cnt = 0; end
            if (ld) begin
                if (s >= NUM_IN) m_err = 1;
                else begin
                    m_prev  = m_out;
                    m_out   = src;
                    m_valid = 1;
                    m_cnt   = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
                end
            end
        end
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out_q"},   out_q,           m_out);
        chk({tag, ".prev_q"},  prev_q,          m_prev);
        chk({tag, ".valid_q"}, 32'(valid_q),    32'(m_valid));
        chk({tag, ".err_q"},   32'(err_q),      32'(m_err));
        chk({tag, ".cnt_q"},   32'(cnt_q),      32'(m_cnt));
    endtask

    typedef struct {
        logic [31:0] a, b, c;
        int          s;
        bit          ld, cl;
        logic [31:0] e_mux, e_out, e_prev;
        bit          e_valid, e_err;
        int          e_cnt;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{32'h10, 32'h20, 32'h30, 2, 1, 0, 32'h30, 32'h30, 32'h00, 1, 0, 1};
        vecs[1] = '{32'h10, 32'h20, 32'h30, 0, 1, 0, 32'h10, 32'h10, 32'h30, 1, 0, 2};
        vecs[2] = '{32'h10, 32'h20, 32'h30, 3, 1, 0, 32'h00, 32'h10, 32'h30, 1, 1, 2};
        vecs[3] = '{32'h10, 32'h20, 32'h30, 0, 0, 1, 32'h10, 32'h10, 32'h30, 0, 0, 0};
        vecs[4] = '{32'hAA, 32'hBB, 32'hCC, 2, 1, 0, 32'hCC, 32'hCC, 32'h10, 1, 0, 1};
        vecs[5] = '{32'hAA, 32'hBB, 32'hCC, 0, 0, 0, 32'hAA, 32'hCC, 32'h10, 1, 0, 1};
        vecs[6] = '{32'hAA, 32'hBB, 32'hCC, 3, 1, 1, 32'h00, 32'hCC, 32'h10, 0, 1, 0};
        vecs[7] = '{32'hAA, 32'hBB, 32'hCC, 0, 1, 1, 32'hAA, 32'hAA, 32'hCC, 1, 0, 1};

        model_reset();
        in_flat = '0; sel = '0; load = 0; clr = 0; rst_n = 0;

        // Reset: two cycles low, mux_c follows sel on idle inputs
        cycle(32'h10, 32'h20, 32'h30, 2, 0, 0, 0);
        cycle(32'h10, 32'h20, 32'h30, 3, 1, 1, 0);
        chk_model("reset");
        chk("reset.out_zero", out_q, 32'h0);
        chk("reset.cnt_zero", 32'(cnt_q), 32'h0);

        // Table-driven vectors from reset state
        foreach (vecs[i]) begin
            cycle(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, vecs[i].ld, vecs[i].cl, 1);
            chk($sformatf("vec%0d.mux_c", i),  last_mux,         vecs[i].e_mux);
            chk($sformatf("vec%0d.out_q", i),  out_q,            vecs[i].e_out);
            chk($sformatf("vec%0d.prev_q", i), prev_q,           vecs[i].e_prev);
            chk($sformatf("vec%0d.valid", i),  32'(valid_q),     32'(vecs[i].e_valid));
            chk($sformatf("vec%0d.err", i),    32'(err_q),       32'(vecs[i].e_err));
            chk($sformatf("vec%0d.cnt", i),    32'(cnt_q),       32'(vecs[i].e_cnt));
        end

        // clr+load with cnt=5
        cycle(32'h1, 32'h2, 32'h3, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) cycle(32'h100 + i, 32'h200, 32'h300, i % 3, 1, 0, 1);
        chk("pre_clrload.cnt", 32'(cnt_q), 32'd5);
        cycle(32'h11, 32'hDEAD, 32'h33, 1, 1, 1, 1);
        chk("clrload.cnt",   32'(cnt_q),   32'd1);
        chk("clrload.valid", 32'(valid_q), 32'd1);
        chk("clrload.err",   32'(err_q),   32'd0);
`ifdef SEL_REG_MUX_CONST_EN
        chk("const.out_q", out_q, 32'h00000004);
`else
        chk("const.out_q", out_q, 32'h0000DEAD);
`endif
        chk_model("clrload");

        // Saturation: 20 consecutive legal loads after clr
        cycle(32'h0, 32'h0, 32'h0, 0, 0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            cycle(32'h1000 + i, 32'h2000 + i, 32'h3000 + i, (i % 2) * 2, 1, 0, 1);
            chk($sformatf("sat%0d.cnt", i), 32'(cnt_q), 32'((i + 1 > 15) ? 15 : i + 1));
            chk($sformatf("sat%0d.out", i), out_q, ((i % 2) == 0) ? 32'h1000 + i : 32'h3000 + i);
            if (i > 0) chk($sformatf("sat%0d.prev", i), prev_q, ((i % 2) == 1) ? 32'h1000 + i - 1 : 32'h3000 + i - 1);
        end

        // Mid-sequence reset with a pending load, then first load after reset
        cycle(32'h5, 32'h6, 32'h7, 3, 1, 0, 1);
        cycle(32'h5, 32'h6, 32'h7, 2, 1, 0, 0);
        chk_model("midreset");
        cycle(32'h5, 32'h6, 32'h7, 2, 1, 0, 1);
        chk("postreset.cnt",  32'(cnt_q), 32'd1);
        chk("postreset.prev", prev_q,     32'h0);
        chk("postreset.out",  out_q,      32'h7);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            cycle($urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), 1);
            chk_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
